// File: rtl/logic_sweep_pkg.sv
// Shared types and constants for the lab-datapath sweep controller.
package logic_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int VEC_W   = 3;
  localparam int DWELL_W = 8;
  localparam int NUM_VEC = 8;

  // {x,y} per vector, vector v at bits [2v+1:2v]
  localparam logic [15:0] GOLDEN_TABLE = 16'hD882;

endpackage

// File: rtl/logic_eval_golden.sv
// Expected datapath response for one input vector, looked up from the golden table.
module logic_eval_golden
  import logic_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] v,
  output logic             x_exp,
  output logic             y_exp
);

  assign {x_exp, y_exp} = GOLDEN_TABLE[{v, 1'b0} +: 2];

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Walks all eight {a,b,c} vectors through the datapath, captures {x,y} after a
// settle time and flags any vector whose response differs from the golden model.
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        c,
  input  logic        x,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_o,
  output logic [7:0]  mismatch_o
);

  localparam logic [DWELL_W-1:0] DWELL_LD = DWELL_W'(DWELL - 1);
  localparam logic [VEC_W-1:0]   LAST_V   = VEC_W'(NUM_VEC - 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   v_q, v_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         abc_q, abc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [15:0]        table_q, table_d;
  logic [7:0]         mism_q, mism_d;
  logic               x_exp, y_exp;

  logic_eval_golden u_gold (
    .v     (v_q),
    .x_exp (x_exp),
    .y_exp (y_exp)
  );

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    dwell_d = dwell_q;
    table_d = table_q;
    mism_d  = mism_q;
    pass_d  = pass_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          v_d     = '0;
          dwell_d = DWELL_LD;
          table_d = '0;
          mism_d  = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (dwell_q == '0) begin
          state_d = SAMPLE;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      SAMPLE: begin
        // An abort here drops the current capture; earlier vectors stay visible.
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          table_d[{v_q, 1'b0} +: 2] = {x, y};
          if ({x, y} != {x_exp, y_exp}) mism_d[v_q] = 1'b1;
          if (v_q == LAST_V) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRIVE;
            v_d     = v_q + 1'b1;
            dwell_d = DWELL_LD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pass_d  = !abort && (mism_q == '0);
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so they register cleanly.
    busy_d = (state_d != IDLE);
    abc_d  = (state_d == DRIVE || state_d == SAMPLE) ? v_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      dwell_q <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      table_q <= '0;
      mism_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      dwell_q <= dwell_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      table_q <= table_d;
      mism_q  <= mism_d;
    end
  end

  assign {a, b, c}  = abc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign table_o    = table_q;
  assign mismatch_o = mism_q;

endmodule

// File: doc/logic_sweep_ctrl.md
# logic_sweep_ctrl

Self-checking sweep controller for the 3-input combinational lab datapath (x = ~c ^ (a|b), y = a & b). On a start request it drives all eight input vectors in order, holds each for a programmable settle time, samples x/y, and compares against a built-in golden model. It reports the captured truth table, a per-vector mismatch map, and pass/done status. It sits between the board-level push-button/LED logic and the datapath instance.

## Interface
- DWELL, 4: settle cycles per vector before sampling; legal range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  sweep request; sampled only in IDLE.
- abort  in  1  cancel the sweep in progress; ignored in IDLE.
- a, b, c  out  1 each  datapath inputs.
- x, y  in  1 each  datapath outputs; combinational response to a/b/c.
- busy  out  1  high in DRIVE, SAMPLE and DONE.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  high when the last completed sweep had zero mismatches.
- table_o  out  16  captured {x,y} per vector: bits [2v+1] = x and [2v] = y.
- mismatch_o  out  8  bit v set if the vector v capture differed from golden.

## Operation
- Vector index v is 3 bits; {a,b,c} = v, with a as the MSB.
- States:
  - IDLE: start=1 → DRIVE. This clears table_o, mismatch_o and pass, sets v=0, and loads dwell_cnt=DWELL-1.
  - DRIVE: dwell_cnt decrements each cycle; dwell_cnt==0 → SAMPLE.
  - SAMPLE:
    - Latch {x,y} into table_o[2v+1:2v].
    - Set mismatch_o[v] if {x,y} != golden(v).
    - If v==7 → DONE; else v+1 and reload dwell_cnt → DRIVE.
  - DONE: done=1; pass is loaded with (mismatch_o==0 including this sweep) → IDLE.
- {a,b,c} = v in DRIVE and SAMPLE, and 0 in IDLE and DONE.
- start while busy is ignored; there is no queuing.
- abort in DRIVE or SAMPLE (also DONE):
  - Next state is IDLE and no done pulse is issued.
  - pass=0.
  - table_o and mismatch_o keep their partial contents.
- abort and start on the same cycle in IDLE: start wins (abort is ignored in IDLE).
- Golden per vector v=0..7, as {x,y}: 10, 00, 00, 10, 00, 10, 01, 11. Full table = 16'hD882.

## Timing
- Reset values:
  - state=IDLE, v=0, dwell_cnt=0.
  - a=b=c=0.
  - busy=0, done=0, pass=0.
  - table_o=16'h0000, mismatch_o=8'h00.
- Reset acts immediately when asserted at any point mid-sweep; all outputs return to their reset values.
- Per vector: DWELL DRIVE cycles plus 1 SAMPLE cycle.
- Edge E0 accepts start. done is high in the single cycle beginning at E0 + 8·(DWELL+1). With DWELL=4 that is 40 cycles later.
- x/y are sampled at the rising edge that ends the SAMPLE cycle. a/b/c have then been stable for DWELL+1 cycles.
- All outputs are registered; none depend combinationally on x, y, start or abort.
- A new start is accepted on the first IDLE cycle after DONE, i.e. one cycle after done.

## Structure
- Package logic_sweep_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, DONE), 2 bits.
  - GOLDEN_TABLE = 16'hD882.
  - VEC_W = 3, DWELL_W = 8.
- Sub-module logic_eval_golden: combinational golden model, v[2:0] → {x_exp, y_exp}. The controller instantiates it rather than indexing the constant, so the bench can reuse it.
- The datapath under control is instantiated outside this block.

## Test plan
- Reset, then start with a correct datapath model, DWELL=4 → done at +40 cycles, table_o=16'hD882, mismatch_o=8'h00, pass=1.
- Datapath model with y stuck-at-0 → table_o=16'h8882, mismatch_o=8'hC0, pass=0.
- DWELL=1 → a/b/c step every 2 cycles; done at +16; start re-asserted during the sweep is ignored; a second start one cycle after done runs a full new sweep.
- abort while in DRIVE of v=3 → IDLE next cycle, no done, pass=0, table_o bits [5:0] hold vectors 0–2, a/b/c=0.
- rst_n pulsed low mid-SAMPLE of v=5 → all outputs at reset values immediately; a following start gives a clean pass.
- Datapath model with delayed x (changes 2 cycles after input), DWELL=4 → pass=1; the same model with DWELL=1 → mismatches flagged.
